// File: rtl/i2s_msb_receiver.sv
// i2s_msb_receiver: MSB-justified I2S capture into a bit-wide circular frame RAM.
// Oversamples BCLK/LRCLK/DATA on clk_i and deserialises 8 slots x 32 bits into
// 256-bit frames. A frame index is published only once a whole frame has
// arrived without a framing error.
// Optional feature: define I2S_MSB_RX_ERR_CNT_EN to add the saturating
// err_count_o output.
module i2s_msb_receiver #(
    parameter int CIRC_BUF_BITS  = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       i2s_bclk_i,
    input  logic                       i2s_lrclk_i,
    input  logic                       i2s_data_i,
    output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
    output logic                       ram_data_o,
    output logic                       ram_we_o,
    output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
    output logic                       i2s_locked_o,
    output logic                       sync_err_o
`ifdef I2S_MSB_RX_ERR_CNT_EN
    ,
    output logic [7:0]                 err_count_o
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StSeek, StReceive} state_t;

    state_t                   state, state_nxt;
    logic                     bclk_s1, bclk_s2, bclk_s3;
    logic                     lrclk_s1, lrclk_s2;
    logic                     data_s1, data_s2;
    logic                     lr_prev, lr_valid;
    logic [TW-1:0]            tmo_cnt;
    logic [7:0]               bit_idx, bit_idx_nxt;
    logic [CIRC_BUF_BITS-1:0] write_frame, frame_nxt, last_good_nxt;
    logic                     locked_nxt, err_nxt, we_nxt, data_nxt;
    logic [CIRC_BUF_BITS+7:0] addr_nxt;
    logic                     rise, boundary, timeout, slot_start;

    assign rise       = bclk_s2 & ~bclk_s3;
    assign boundary   = rise & lr_valid & (lrclk_s2 != lr_prev);
    assign timeout    = ~rise & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign slot_start = (bit_idx[4:0] == 5'd0);

    // Two-flop synchronisers for the external clocks/data, plus a third BCLK flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bclk_s1  <= 1'b0;
            bclk_s2  <= 1'b0;
            bclk_s3  <= 1'b0;
            lrclk_s1 <= 1'b0;
            lrclk_s2 <= 1'b0;
            data_s1  <= 1'b0;
            data_s2  <= 1'b0;
        end else begin
            bclk_s1  <= i2s_bclk_i;
            bclk_s2  <= bclk_s1;
            bclk_s3  <= bclk_s2;
            lrclk_s1 <= i2s_lrclk_i;
            lrclk_s2 <= lrclk_s1;
            data_s1  <= i2s_data_i;
            data_s2  <= data_s1;
        end
    end

    // Remember LRCLK at every BCLK rise so slot boundaries can be spotted; lr_valid blocks a false boundary right after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lr_prev  <= 1'b0;
            lr_valid <= 1'b0;
        end else if (rise) begin
            lr_prev  <= lrclk_s2;
            lr_valid <= 1'b1;
        end
    end

    // Loss-of-clock counter: cleared by each BCLK rise, saturates so a stall raises only one timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (rise || state == StIdle) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // State register and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                 <= StIdle;
            bit_idx               <= 8'd0;
            write_frame           <= '0;
            last_good_frame_idx_o <= '0;
            i2s_locked_o          <= 1'b0;
            sync_err_o            <= 1'b0;
            ram_we_o              <= 1'b0;
            ram_data_o            <= 1'b0;
            ram_write_addr_o      <= '0;
        end else begin
            state                 <= state_nxt;
            bit_idx               <= bit_idx_nxt;
            write_frame           <= frame_nxt;
            last_good_frame_idx_o <= last_good_nxt;
            i2s_locked_o          <= locked_nxt;
            sync_err_o            <= err_nxt;
            ram_we_o              <= we_nxt;
            ram_data_o            <= data_nxt;
            ram_write_addr_o      <= addr_nxt;
        end
    end

    // Next-state logic: frame alignment, per-bit writes, framing checks and frame completion
    always_comb begin
        state_nxt     = state;
        bit_idx_nxt   = bit_idx;
        frame_nxt     = write_frame;
        last_good_nxt = last_good_frame_idx_o;
        locked_nxt    = i2s_locked_o;
        err_nxt       = 1'b0;
        we_nxt        = 1'b0;
        data_nxt      = ram_data_o;
        addr_nxt      = ram_write_addr_o;
        if (!enable_i) begin
            state_nxt   = StIdle;
            bit_idx_nxt = 8'd0;
            locked_nxt  = 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    state_nxt   = StSeek;
                    bit_idx_nxt = 8'd0;
                end
                StSeek: begin
                    if (boundary && lrclk_s2) begin
                        we_nxt      = 1'b1;
                        addr_nxt    = {write_frame, 8'd0};
                        data_nxt    = data_s2;
                        bit_idx_nxt = 8'd1;
                        state_nxt   = StReceive;
                    end else if (timeout) begin
                        locked_nxt = 1'b0;
                    end
                end
                StReceive: begin
                    if (rise) begin
                        if ((boundary != slot_start) || (bit_idx == 8'd0 && !lrclk_s2)) begin
                            err_nxt     = 1'b1;
                            locked_nxt  = 1'b0;
                            bit_idx_nxt = 8'd0;
                            state_nxt   = StSeek;
                        end else begin
                            we_nxt      = 1'b1;
                            addr_nxt    = {write_frame, bit_idx};
                            data_nxt    = data_s2;
                            bit_idx_nxt = bit_idx + 8'd1;
                            if (bit_idx == 8'd255) begin
                                last_good_nxt = write_frame;
                                frame_nxt     = write_frame + 1'b1;
                                locked_nxt    = 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        err_nxt     = 1'b1;
                        locked_nxt  = 1'b0;
                        bit_idx_nxt = 8'd0;
                        state_nxt   = StSeek;
                    end
                end
                default: begin
                    state_nxt = StIdle;
                end
            endcase
        end
    end

`ifdef I2S_MSB_RX_ERR_CNT_EN
    // Saturating count of sync_err_o pulses, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_o <= 8'd0;
        end else if (sync_err_o && err_count_o != 8'hFF) begin
            err_count_o <= err_count_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_msb_receiver.sv
// tb_i2s_msb_receiver: directed I2S streams with a queue-based write model.
module tb_i2s_msb_receiver;

    localparam int CB  = 3;
    localparam int TMO = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni, enable_i, bclk, lrclk, data;
    logic [CB+7:0] ram_write_addr_o;
    logic          ram_data_o, ram_we_o, i2s_locked_o, sync_err_o;
    logic [CB-1:0] last_good_frame_idx_o;
`ifdef I2S_MSB_RX_ERR_CNT_EN
    logic [7:0]    err_count_o;
`endif

    i2s_msb_receiver #(.CIRC_BUF_BITS(CB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .enable_i              (enable_i),
        .i2s_bclk_i            (bclk),
        .i2s_lrclk_i           (lrclk),
        .i2s_data_i            (data),
        .ram_write_addr_o      (ram_write_addr_o),
        .ram_data_o            (ram_data_o),
        .ram_we_o              (ram_we_o),
        .last_good_frame_idx_o (last_good_frame_idx_o),
        .i2s_locked_o          (i2s_locked_o),
        .sync_err_o            (sync_err_o)
`ifdef I2S_MSB_RX_ERR_CNT_EN
        ,
        .err_count_o           (err_count_o)
`endif
    );

    // System clock
    always #5 clk_i = ~clk_i;

    int            checks = 0;
    int            errors = 0;
    int            err_pulses = 0;
    int            wr_seen = 0;
    logic [CB+8:0] exp_q[$];
    logic          exp_ram[0:2047];
    logic          dut_ram[0:2047];
    int            model_frame = 0;
    logic          model_locked = 1'b0;

    function automatic logic [31:0] slot_word(input int tag, input int k);
        return 32'hA5000000 | (32'(tag) << 8) | 32'(k);
    endfunction

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input int fr, input int idx, input logic b);
        logic [CB+7:0] a;
        a = {fr[CB-1:0], idx[7:0]};
        exp_q.push_back({a, b});
        exp_ram[a] = b;
    endtask

    task automatic apply_bit(input logic lr, input logic d);
        bclk  = 1'b0;
        lrclk = lr;
        data  = d;
        repeat (4) @(negedge clk_i);
        bclk = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic apply_word(input logic lr, input logic [31:0] w, input int nbits,
                              input bit wr, input int fr, input int start);
        for (int i = 0; i < nbits; i++) begin
            if (wr) expect_write(fr, start + i, w[31-i]);
            apply_bit(lr, w[31-i]);
        end
    endtask

    task automatic apply_good_frame(input int tag);
        int e0;
        int lg;
        e0 = err_pulses;
        for (int k = 0; k < 8; k++) begin
            apply_word(k % 2 == 0, slot_word(tag, k), 32, 1, model_frame, k * 32);
            if (k == 0) check_output("locked_mid_frame", i2s_locked_o, model_locked);
        end
        lg           = model_frame;
        model_frame  = (model_frame + 1) % (1 << CB);
        model_locked = 1'b1;
        check_output("last_good_after_frame", last_good_frame_idx_o, lg);
        check_output("locked_after_frame", i2s_locked_o, 1);
        check_output("no_err_in_good_frame", err_pulses, e0);
    endtask

    initial begin
        int e0;
        int first_idx;
        int pulses;
        int bad;
        for (int i = 0; i < 2048; i++) begin
            exp_ram[i] = 1'b0;
            dut_ram[i] = 1'b0;
        end
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        bclk     = 1'b0;
        lrclk    = 1'b0;
        data     = 1'b0;

        // Compare process: every write strobe must match the next expected write
        fork
            forever begin
                logic [CB+8:0] e;
                @(negedge clk_i);
                if (rst_ni) begin
                    if (sync_err_o) err_pulses++;
                    if (ram_we_o) begin
                        wr_seen++;
                        dut_ram[ram_write_addr_o] = ram_data_o;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL unexpected_write: got addr %0h data %0b, wanted no write",
                                     ram_write_addr_o, ram_data_o);
                        end else begin
                            e = exp_q.pop_front();
                            if (e != {ram_write_addr_o, ram_data_o}) begin
                                errors++;
                                $display("[TB] FAIL write: got addr %0h data %0b, wanted addr %0h data %0b",
                                         ram_write_addr_o, ram_data_o, e[CB+8:1], e[0]);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk_i);
        check_output("reset_we", ram_we_o, 0);
        check_output("reset_addr", ram_write_addr_o, 0);
        check_output("reset_data", ram_data_o, 0);
        check_output("reset_last_good", last_good_frame_idx_o, 0);
        check_output("reset_locked", i2s_locked_o, 0);
        check_output("reset_sync_err", sync_err_o, 0);
`ifdef I2S_MSB_RX_ERR_CNT_EN
        check_output("reset_err_count", err_count_o, 0);
`endif
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Enable asserted inside an lrclk-low slot: nothing written until the next 0->1 boundary
        apply_word(1'b1, 32'hFFFF_FFFF, 32, 0, 0, 0);
        apply_word(1'b0, 32'hF000_0000, 5, 0, 0, 0);
        enable_i = 1'b1;
        apply_word(1'b0, 32'hFFFF_FFFF, 27, 0, 0, 0);
        check_output("writes_before_align", wr_seen, 0);

        // Clean stream: three frames
        apply_good_frame(0);
        check_output("last_good_literal_f0", last_good_frame_idx_o, 3'd0);
        apply_good_frame(0);
        apply_good_frame(0);
        check_output("last_good_literal_f2", last_good_frame_idx_o, 3'd2);
        check_output("strobes_three_frames", wr_seen, 768);

        // Short slot: slot 3 carries 31 bits, the next boundary lands mid-slot
        e0 = err_pulses;
        for (int k = 0; k < 3; k++)
            apply_word(k % 2 == 0, slot_word(9, k), 32, 1, model_frame, k * 32);
        apply_word(1'b0, slot_word(9, 3), 31, 1, model_frame, 96);
        apply_word(1'b1, slot_word(9, 4), 32, 0, 0, 0);
        model_locked = 1'b0;
        check_output("short_slot_err_pulses", err_pulses, e0 + 1);
        check_output("short_slot_locked", i2s_locked_o, 0);
        check_output("short_slot_last_good", last_good_frame_idx_o, 3'd2);
        apply_word(1'b0, 32'h0, 32, 0, 0, 0);
        apply_good_frame(1);
        check_output("after_short_slot_frame", last_good_frame_idx_o, 3'd3);

        // Clock loss mid-frame
        apply_word(1'b1, slot_word(2, 0), 32, 1, model_frame, 0);
        apply_word(1'b0, slot_word(2, 1), 32, 1, model_frame, 32);
        apply_word(1'b1, slot_word(2, 2), 5, 1, model_frame, 64);
        bclk      = 1'b0;
        first_idx = -1;
        pulses    = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (sync_err_o) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
            end
        end
        model_locked = 1'b0;
        check_output("timeout_pulse_count", pulses, 1);
        check_output("timeout_in_window", (first_idx >= 55 && first_idx <= 70), 1);
        check_output("timeout_locked", i2s_locked_o, 0);
        apply_word(1'b0, 32'h0, 32, 0, 0, 0);
        apply_good_frame(2);
        check_output("after_timeout_frame", last_good_frame_idx_o, 3'd4);

        // Wrap-around of the circular buffer
        for (int t = 3; t < 7; t++) apply_good_frame(t);
        check_output("wrap_last_good", last_good_frame_idx_o, 3'd0);

        // Enable dropped mid-frame: partial frame abandoned, index kept
        apply_word(1'b1, slot_word(8, 0), 32, 1, model_frame, 0);
        apply_word(1'b0, slot_word(8, 1), 32, 1, model_frame, 32);
        enable_i = 1'b0;
        repeat (3) @(negedge clk_i);
        model_locked = 1'b0;
        check_output("disable_locked", i2s_locked_o, 0);
        check_output("disable_last_good", last_good_frame_idx_o, 3'd0);
        enable_i = 1'b1;
        repeat (2) @(negedge clk_i);
        apply_word(1'b0, 32'h0, 32, 0, 0, 0);
        apply_good_frame(7);
        check_output("reenable_frame", last_good_frame_idx_o, 3'd1);

`ifdef I2S_MSB_RX_ERR_CNT_EN
        // 300 framing errors saturate the error counter
        e0 = err_pulses;
        apply_bit(1'b0, 1'b0);
        for (int i = 0; i < 299; i++) begin
            expect_write(model_frame, 0, 1'b1);
            apply_bit(1'b1, 1'b1);
            apply_bit(1'b0, 1'b0);
        end
        repeat (3) @(negedge clk_i);
        check_output("err_pulses_300", err_pulses, e0 + 300);
        check_output("err_count_sat", err_count_o, 8'hFF);
`endif

        // Final: every expected write seen, RAM image matches
        repeat (10) @(negedge clk_i);
        check_output("pending_writes", exp_q.size(), 0);
        for (int f = 0; f < 8; f++) begin
            bad = 0;
            for (int b = 0; b < 256; b++)
                if (dut_ram[f*256+b] !== exp_ram[f*256+b]) bad++;
            check_output($sformatf("ram_frame_%0d", f), bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_msb_receiver.md
Name: i2s_msb_receiver

Overview:
- MSB-justified I2S receiver: oversamples external BCLK/LRCLK/DATA on the system clock and deserialises 8 slots of 32 bits (4 stereo pairs) into 256-bit frames.
- Each bit is written into a bit-wide circular frame RAM; a frame index is published only after the whole frame arrives with no framing error.
- It is the capture-side counterpart of the MSB-justified transmitter, and feeds the ADAT encoder path.

Parameters:
- CIRC_BUF_BITS, 3, log2 of the number of 256-bit frames in the circular RAM.
- TIMEOUT_CYCLES, 64, clk_i cycles without a BCLK rising edge before declaring loss of clock.

Ports:
- clk_i  in  1  system clock; must be at least 4x the BCLK frequency.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  receiver enable; low forces StIdle.
- i2s_bclk_i  in  1  external bit clock (asynchronous).
- i2s_lrclk_i  in  1  external word clock (asynchronous); high = even (left) slot.
- i2s_data_i  in  1  serial data; changes on BCLK falling edge.
- ram_write_addr_o  out  CIRC_BUF_BITS+8  {write_frame, bit_idx}.
- ram_data_o  out  1  bit to write.
- ram_we_o  out  1  one-cycle write strobe.
- last_good_frame_idx_o  out  CIRC_BUF_BITS  index of the most recent complete frame.
- i2s_locked_o  out  1  high once at least one good frame has been received since the last error.
- sync_err_o  out  1  one-cycle pulse on a framing error or timeout.

Behaviour:
- Reset values: all outputs 0; write_frame_r = 0; state = StIdle.
- Input synchronisation: bclk, lrclk and data each pass through 2-FF synchronisers; a third BCLK flop provides edge detection.
- A BCLK rise is detected in cycle N when bclk_s2 = 1 and bclk_s3 = 0. At that edge, data_s2 and lrclk_s2 are sampled.
- Slot boundary: the sampled lrclk differs from its value at the previous rise. MSB-justified, so the bit sampled at the boundary is bit 31 (the MSB) of the new slot; there is no one-bit delay.
- Bit index bit_idx[7:0]: the first bit after frame alignment is 0; increments by 1 per BCLK rise.
- State machine (3 states):
  - StIdle: no writes. Goes to StSeek when enable_i = 1.
  - StSeek: wait for an lrclk 0->1 boundary. At that rise, write the bit at bit_idx = 0 and go to StReceive.
  - StReceive: write each bit at {write_frame_r, bit_idx}.
    - Expected boundaries: only when bit_idx wraps to a multiple of 32.
    - Boundary at bit_idx[4:0] != 0, or no boundary at a multiple of 32: framing error. Pulse sync_err_o, clear i2s_locked_o, keep write_frame_r unchanged (the partial frame gets overwritten), go to StSeek.
    - After bit 255 is written without error: last_good_frame_idx_o <= write_frame_r; write_frame_r increments mod 2^CIRC_BUF_BITS; i2s_locked_o <= 1; bit_idx wraps to 0.
    - The next frame must begin with an lrclk 0->1 boundary.
- Write timing: ram_we_o, ram_data_o and ram_write_addr_o are registered and valid in cycle N+1 after the detected rise. Exactly one strobe is issued per received bit.
- Timeout: a counter resets on every BCLK rise. Reaching TIMEOUT_CYCLES in StReceive or StSeek pulses sync_err_o (in StReceive only), clears i2s_locked_o and goes to StSeek.
- enable_i low in any state: go to StIdle next cycle, abort any partial frame, clear i2s_locked_o. last_good_frame_idx_o and write_frame_r are kept.
- Reset mid-frame: all state returns to reset values immediately (asynchronous).
- Simultaneous events: a timeout and a BCLK rise in the same cycle resolve in favour of the rise. Any error takes priority over frame completion.

Optional Feature:
- Macro: I2S_MSB_RX_ERR_CNT_EN.
- Defined: adds output err_count_o [7:0]. It increments on every sync_err_o pulse, saturates at 8'hFF, and resets to 0 only via rst_ni.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Clean stream: BCLK = clk/8, 3 consecutive frames with pattern data (slot k word = 32'hA5000000 | k) -> 768 write strobes, RAM contents match, last_good_frame_idx_o = 0, 1, 2 in sequence, i2s_locked_o rises after bit 255 of frame 0.
- Mid-stream enable: assert enable_i during an odd (lrclk low) slot -> no writes until the next lrclk 0->1 boundary; the first write is at address {0, 8'd0} with the MSB of slot 0.
- Short slot: lrclk toggles after 31 bits in slot 3 of frame 1 -> sync_err_o pulses once, i2s_locked_o = 0, last_good_frame_idx_o stays 0, and the next good frame is written to frame index 1.
- Clock loss: stop BCLK for 100 cycles mid-frame (TIMEOUT_CYCLES = 64) -> sync_err_o pulses at cycle 64, state returns to StSeek, and recovery occurs on the next lrclk rise.
- Wrap-around: 9 good frames with CIRC_BUF_BITS = 3 -> the ninth frame is written at frame index 0; last_good_frame_idx_o sequence 0..7 then 0.
- With I2S_MSB_RX_ERR_CNT_EN defined: inject 300 framing errors -> err_count_o = 8'hFF.
